// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule controller.
//   KEY_W          : width of a cipher key / round key
//   DEF_NUM_ROUNDS : default number of expansion rounds (AES-128 = 10)
//   round_t        : 4-bit round index, 0..15
//   ks_state_t     : controller FSM states
package aes_pkg;

    localparam int KEY_W          = 128;
    localparam int DEF_NUM_ROUNDS = 10;

    typedef logic [3:0] round_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        READY = 3'd3,
        ERROR = 3'd4
    } ks_state_t;

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Link between the key schedule controller and the single-round key
// expansion stage.
//
// Handshake: the master raises exp_enable for exactly one cycle with
// exp_old_key / exp_round_num valid; both stay stable until the slave
// answers. The slave raises exp_done for one cycle with exp_new_key valid in
// that same cycle. There is no backpressure; exp_done is the only response.
//
//   exp_enable    master->slave  start pulse
//   exp_old_key   master->slave  previous round key
//   exp_round_num master->slave  round being computed (1..NUM_ROUNDS)
//   exp_new_key   slave->master  expanded key
//   exp_done      slave->master  exp_new_key valid this cycle
interface key_schedule_ctrl_if;
    import aes_pkg::*;

    logic             exp_enable;
    logic [KEY_W-1:0] exp_old_key;
    round_t           exp_round_num;
    logic [KEY_W-1:0] exp_new_key;
    logic             exp_done;

    modport master (
        output exp_enable, exp_old_key, exp_round_num,
        input  exp_new_key, exp_done
    );

    modport slave (
        input  exp_enable, exp_old_key, exp_round_num,
        output exp_new_key, exp_done
    );

endinterface

// File: rtl/round_key_regfile.sv
// Round key store: DEPTH entries of KEY_W bits.
//   clk, n_rst : clock, asynchronous active-low clear of every entry
//   wr_en      : write wr_data into entry wr_idx at the clock edge
//   wr_idx     : write index
//   wr_data    : write data
//   rd_idx     : read index, sampled every clock edge
//   rd_data    : registered read data; 0 when rd_idx is out of range
// A read and write to the same entry in one cycle returns the old content.
module round_key_regfile
    import aes_pkg::*;
#(
    parameter int DEPTH = DEF_NUM_ROUNDS + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en,
    input  round_t           wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  round_t           rd_idx,
    output logic [KEY_W-1:0] rd_data
);

    logic [KEY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en && (int'(wr_idx) < DEPTH)) begin
                mem[wr_idx] <= wr_data;
            end
            if (int'(rd_idx) < DEPTH) begin
                rd_data <= mem[rd_idx];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Key schedule sequencer: captures a cipher key, runs the external
// single-round expansion stage once per round, stores every round key and
// serves them by index to the cipher datapath.
//   clk, n_rst    : clock, asynchronous active-low reset
//   key_load      : one-cycle pulse, capture cipher_key and start
//   cipher_key    : round-0 key
//   busy          : schedule in progress
//   keys_ready    : all round keys valid
//   key_error     : expansion stage did not answer in time
//   exp_if        : master side of the expansion-stage link
//   rd_round      : requested round key index
//   rd_key        : registered round key for rd_round (1-cycle latency)
//   dbg_state     : current FSM state, for observation only
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = DEF_NUM_ROUNDS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       key_load,
    input  logic [KEY_W-1:0]           cipher_key,
    output logic                       busy,
    output logic                       keys_ready,
    output logic                       key_error,
    key_schedule_ctrl_if.master        exp_if,
    input  round_t                     rd_round,
    output logic [KEY_W-1:0]           rd_key,
    output ks_state_t                  dbg_state
);

    localparam int     TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);
    // The counter is 0 in the first WAIT cycle. Leaving on this value means
    // the increment would have reached TIMEOUT_CYCLES-1 at this edge, so
    // key_error rises exactly TIMEOUT_CYCLES cycles after exp_enable.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    ks_state_t        state;
    round_t           round_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             wr_en;
    round_t           wr_idx;
    logic [KEY_W-1:0] wr_data;

    assign dbg_state = state;

    // Store writes: round 0 on a (re)start, round_cnt on exp_done in WAIT.
    // exp_done in any other state never reaches the store.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        case (state)
            IDLE, READY, ERROR: begin
                if (key_load) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    wr_data = cipher_key;
                end
            end
            WAIT: begin
                if (exp_if.exp_done) begin
                    wr_en   = 1'b1;
                    wr_idx  = round_cnt;
                    wr_data = exp_if.exp_new_key;
                end
            end
            default: ;
        endcase
    end

    // exp_old_key is loaded from the value being written to
    // store[round_cnt-1] in the same cycle, so the expansion stage always
    // sees the previous round key without a read of the store.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= IDLE;
            round_cnt            <= '0;
            to_cnt               <= '0;
            busy                 <= 1'b0;
            keys_ready           <= 1'b0;
            key_error            <= 1'b0;
            exp_if.exp_enable    <= 1'b0;
            exp_if.exp_old_key   <= '0;
            exp_if.exp_round_num <= '0;
        end else begin
            exp_if.exp_enable <= 1'b0;
            case (state)
                IDLE, READY, ERROR: begin
                    if (key_load) begin
                        state                <= REQ;
                        round_cnt            <= round_t'(1);
                        busy                 <= 1'b1;
                        keys_ready           <= 1'b0;
                        key_error            <= 1'b0;
                        exp_if.exp_enable    <= 1'b1;
                        exp_if.exp_old_key   <= cipher_key;
                        exp_if.exp_round_num <= round_t'(1);
                    end
                end
                REQ: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    // exp_done takes priority over an expiring timeout.
                    if (exp_if.exp_done) begin
                        if (round_cnt == LAST_ROUND) begin
                            state      <= READY;
                            busy       <= 1'b0;
                            keys_ready <= 1'b1;
                        end else begin
                            state                <= REQ;
                            round_cnt            <= round_cnt + round_t'(1);
                            exp_if.exp_enable    <= 1'b1;
                            exp_if.exp_old_key   <= exp_if.exp_new_key;
                            exp_if.exp_round_num <= round_cnt + round_t'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state     <= ERROR;
                        busy      <= 1'b0;
                        key_error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    round_key_regfile #(
        .DEPTH (NUM_ROUNDS + 1)
    ) u_regfile (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_round),
        .rd_data (rd_key)
    );

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencer and round-key store around the single-round key expansion stage.
- Upstream role: accepts a 128-bit cipher key. Drives the expansion stage once per round (rounds 1..NUM_ROUNDS), feeding each result back as the next input.
- Downstream role: captures every returned round key into an 11-entry store. Serves keys by round index to the cipher datapath (AddRoundKey).

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; the store holds NUM_ROUNDS+1 keys.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for exp_done before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; one clock, asynchronous, active-low.
- key_load  in  1  single-cycle pulse; capture cipher_key and start the schedule.
- cipher_key  in  128  initial key (round 0).
- busy  out  1  schedule in progress.
- keys_ready  out  1  all round keys valid.
- key_error  out  1  expansion stage timed out.
- exp_enable  out  1  single-cycle start pulse to the expansion stage.
- exp_old_key  out  128  previous round key, to the expansion stage.
- exp_round_num  out  4  round being computed, 1..NUM_ROUNDS.
- exp_new_key  in  128  expanded key from the expansion stage.
- exp_done  in  1  expansion complete; exp_new_key valid this cycle.
- rd_round  in  4  round key index requested by the datapath.
- rd_key  out  128  registered round key for rd_round.

Behaviour:
- Reset, asynchronous on n_rst low:
  - State IDLE; round_cnt=0; timeout counter=0.
  - Every store entry cleared to 0.
  - All outputs 0.
- State IDLE:
  - On key_load: store[0]<=cipher_key; round_cnt<=1; go to REQ.
  - busy is 1 from the next cycle.
- State REQ, exactly one cycle:
  - exp_enable=1.
  - exp_old_key=store[round_cnt-1]; exp_round_num=round_cnt. Both are registered and held stable through WAIT.
  - Timeout counter cleared. Go to WAIT.
- State WAIT:
  - Timeout counter increments each cycle.
  - On exp_done: store[round_cnt]<=exp_new_key.
    - If round_cnt==NUM_ROUNDS: go to READY.
    - Otherwise: round_cnt<=round_cnt+1; go to REQ.
  - If the counter reaches TIMEOUT_CYCLES-1 without exp_done: go to ERROR.
  - If exp_done and timeout occur in the same cycle, exp_done wins.
- exp_done outside WAIT: ignored. A stray exp_done must not alter the store.
- State READY:
  - keys_ready=1; busy=0.
  - On key_load: restart exactly as from IDLE. keys_ready falls the next cycle; old keys stay readable in store[1..] until overwritten.
- State ERROR:
  - key_error=1; busy=0; keys_ready=0.
  - Left only via key_load, which clears key_error and restarts.
- key_load while in REQ or WAIT: ignored.
- Read port:
  - rd_key<=store[rd_round] on every clock edge; 1-cycle latency.
  - Valid in every state; content is meaningful only while keys_ready=1.
  - rd_round>NUM_ROUNDS: rd_key<=0.
- Full schedule latency: key_load to keys_ready = 1 + sum over rounds of (1 + expansion latency + 1) cycles.
- No arithmetic besides the 4-bit round_cnt and a counter of width clog2(TIMEOUT_CYCLES). round_cnt never exceeds NUM_ROUNDS.

Decomposition:
- Shared package aes_pkg holds:
  - KEY_W=128.
  - NUM_ROUNDS default.
  - Round-index type (4-bit).
  - State enum {IDLE, REQ, WAIT, READY, ERROR}.
- One sub-module: round_key_regfile.
  - (NUM_ROUNDS+1) x 128 storage.
  - One synchronous write port, one registered read port.
  - Out-of-range read returns 0.
  - Asynchronous clear on n_rst.

Test Plan:
- Reset: assert n_rst low mid-WAIT -> all outputs 0, state IDLE, rd_key=0 for every rd_round after release.
- Full schedule: cipher_key=2b7e151628aed2a6abf7158809cf4f3c, bench drives a behavioural expansion model (3-cycle latency) -> 10 exp_enable pulses with exp_round_num 1..10, then keys_ready=1. rd_round=1 gives a0fafe1788542cb123a339392a6c7605 one cycle later; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Timeout: model never asserts exp_done in round 3 -> key_error=1 exactly TIMEOUT_CYCLES cycles after the round-3 exp_enable; busy=0. A following key_load clears key_error and restarts at round 1.
- Ignored events: key_load pulsed during WAIT of round 5, plus a stray exp_done in READY -> schedule completes unchanged; store contents unchanged.
- Read boundaries: rd_round=0 -> cipher_key; rd_round=11 and 15 -> 0; rd_round changed every cycle -> rd_key tracks with exactly 1-cycle lag.
- Reload: key_load with an all-zero key in READY -> keys_ready low next cycle; the schedule reruns; rd_round=10 yields b4ef5bcb3e92e21123e951cf6f8f188e.
